// File: rtl/ws2812_led_driver_if.sv
// Host-side write port of the WS2812 driver: one strobe writes one colour word into the LED table.
interface ws2812_led_driver_if;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic        write;

  modport master (output led_num, output rgb_data, output write);
  modport slave  (input  led_num, input  rgb_data, input  write);
endinterface

// File: rtl/ws2812_led_driver.sv
// WS2812 chain driver: keeps a colour table and refreshes the whole chain from it forever,
// with a low latch period between frames.
module ws2812_led_driver #(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned T0H_CYC   = 4,
  parameter int unsigned T1H_CYC   = 8,
  parameter int unsigned BIT_CYC   = 15,
  parameter int unsigned RESET_CYC = 600
) (
  input  logic                      clk,
  input  logic                      reset,
  ws2812_led_driver_if.slave        bus,
  output logic                      data
);

  localparam int unsigned LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned CNT_MAX = (RESET_CYC > BIT_CYC) ? RESET_CYC : BIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {LATCH, SEND} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [LED_W-1:0]   led_idx;
  logic [4:0]         bit_idx;
  logic [23:0]        shift;
  logic [23:0]        table_q [NUM_LEDS];

  logic               wr_ok_c;
  logic               latch_done_c;
  logic               bit_end_c;
  logic               led_end_c;
  logic               frame_end_c;
  logic [CNT_W-1:0]   high_cyc_c;
  logic               data_nxt_c;
  logic [LED_W-1:0]   led_nxt_c;

  assign wr_ok_c      = bus.write && ({1'b0, bus.led_num} < 9'(NUM_LEDS));
  assign latch_done_c = (cnt == CNT_W'(RESET_CYC - 1));
  assign bit_end_c    = (cnt == CNT_W'(BIT_CYC - 1));
  assign led_end_c    = bit_end_c && (bit_idx == 5'd0);
  assign frame_end_c  = led_end_c && (led_idx == LED_W'(NUM_LEDS - 1));
  assign led_nxt_c    = led_idx + LED_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= LATCH;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LATCH:   if (latch_done_c) state_nxt = SEND;
      SEND:    if (frame_end_c)  state_nxt = LATCH;
      default: state_nxt = LATCH;
    endcase
  end

  // Output decode: pulse high for the first T0H/T1H cycles of each bit slot
  always_comb begin
    high_cyc_c = shift[23] ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    data_nxt_c = 1'b0;
    if (state == SEND) data_nxt_c = (cnt < high_cyc_c);
  end

  // Datapath: table, bit/LED sequencing and registered pin
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      led_idx <= '0;
      bit_idx <= 5'd23;
      shift   <= '0;
      data    <= 1'b0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) table_q[i] <= '0;
    end else begin
      data <= data_nxt_c;
      if (wr_ok_c) table_q[bus.led_num[LED_W-1:0]] <= bus.rgb_data;

      case (state)
        LATCH: begin
          if (latch_done_c) begin
            cnt     <= '0;
            led_idx <= '0;
            bit_idx <= 5'd23;
            shift   <= table_q[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SEND: begin
          if (!bit_end_c) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (!led_end_c) begin
              shift   <= {shift[22:0], 1'b0};
              bit_idx <= bit_idx - 5'd1;
            end else if (!frame_end_c) begin
              // Next LED's colour is sampled here, so it starts with no gap
              led_idx <= led_nxt_c;
              bit_idx <= 5'd23;
              shift   <= table_q[led_nxt_c];
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_led_driver.sv
// Bench for ws2812_led_driver: positional waveform model of the frame plus frame-level vectors.
module tb_ws2812_led_driver;

  localparam int NUM_LEDS  = 8;
  localparam int T0H_CYC   = 4;
  localparam int T1H_CYC   = 8;
  localparam int BIT_CYC   = 15;
  localparam int RESET_CYC = 600;
  localparam int LED_CYC   = 24 * BIT_CYC;
  localparam int FRAME_CYC = RESET_CYC + NUM_LEDS * LED_CYC;

  logic clk = 1'b0;
  logic reset;
  logic data;

  ws2812_led_driver_if bus ();

  ws2812_led_driver #(
    .NUM_LEDS(NUM_LEDS), .T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC),
    .BIT_CYC(BIT_CYC), .RESET_CYC(RESET_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .data (data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;
  int high_acc = 0;
  logic exp_d = 1'b0;
  logic [23:0] mtab [NUM_LEDS];
  logic [23:0] snap [NUM_LEDS];

  typedef struct {
    logic        wr;
    int          ln;
    logic [23:0] rgb;
    int          exp_high;
  } vec_t;

  vec_t vecs [7];

  // Pin level expected for a frame position, from the colours captured at each LED's start
  function automatic logic expect_of(input int p);
    int q, led, r, bitn, c;
    logic b;
    if (p < RESET_CYC) return 1'b0;
    q    = p - RESET_CYC;
    led  = q / LED_CYC;
    r    = q % LED_CYC;
    bitn = 23 - r / BIT_CYC;
    c    = r % BIT_CYC;
    b    = snap[led][bitn];
    return c < (b ? T1H_CYC : T0H_CYC);
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b required %0b (t=%0d)", name, act, req, t);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // One clock: drive inputs, advance model across the edge, compare the pin
  task automatic step(input logic rst, input logic wr, input int ln, input logic [23:0] rgb);
    int p;
    reset         = rst;
    bus.write     = wr;
    bus.led_num   = 8'(ln);
    bus.rgb_data  = rgb;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        mtab[i] = '0;
        snap[i] = '0;
      end
      t     = 0;
      exp_d = 1'b0;
    end else begin
      exp_d = expect_of(t % FRAME_CYC);
      t++;
      p = t % FRAME_CYC;
      if (p >= RESET_CYC && (p - RESET_CYC) % LED_CYC == 0)
        snap[(p - RESET_CYC) / LED_CYC] = mtab[(p - RESET_CYC) / LED_CYC];
      if (wr && ln < NUM_LEDS) mtab[ln] = rgb;
    end
    #1;
    check_bit("data_model", data, exp_d);
    high_acc += int'(data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 24'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0, 24'h0);
    step(1'b1, 1'b1, 2, 24'hFFFFFF);
  endtask

  initial begin
    reset        = 1'b1;
    bus.write    = 1'b0;
    bus.led_num  = '0;
    bus.rgb_data = '0;

    vecs[0] = '{1'b0, 0,   24'h000000, 768};
    vecs[1] = '{1'b1, 0,   24'hFF0000, 800};
    vecs[2] = '{1'b1, 7,   24'h000001, 772};
    vecs[3] = '{1'b1, 8,   24'hFFFFFF, 768};
    vecs[4] = '{1'b1, 3,   24'hAAAAAA, 816};
    vecs[5] = '{1'b1, 255, 24'hFFFFFF, 768};
    vecs[6] = '{1'b1, 5,   24'hFFFFFF, 864};

    do_reset();
    check_bit("reset_data", data, 1'b0);

    // Each vector: fresh table, one write, then the total high time of the following frame
    foreach (vecs[k]) begin
      do_reset();
      high_acc = 0;
      step(1'b0, vecs[k].wr, vecs[k].ln, vecs[k].rgb);
      idle(FRAME_CYC - 1);
      check_int($sformatf("frame_high_v%0d", k), high_acc, vecs[k].exp_high);
    end

    // Write to LED0 while it is shifting: old colour this frame, new one next frame
    do_reset();
    high_acc = 0;
    idle(RESET_CYC + 100);
    step(1'b0, 1'b1, 0, 24'hAAAAAA);
    idle(FRAME_CYC - RESET_CYC - 101);
    check_int("live_write_cur_frame", high_acc, 768);
    high_acc = 0;
    idle(FRAME_CYC);
    check_int("live_write_next_frame", high_acc, 816);

    // Reset in the middle of a '1' bit of LED3 aborts the frame and clears the table
    do_reset();
    for (int i = 0; i < NUM_LEDS; i++) step(1'b0, 1'b1, i, 24'hFFFFFF);
    idle(RESET_CYC + 3 * LED_CYC + 13 * BIT_CYC + 2 - NUM_LEDS);
    check_bit("pre_abort_high", data, 1'b1);
    step(1'b1, 1'b0, 0, 24'h0);
    check_bit("abort_low", data, 1'b0);
    high_acc = 0;
    idle(FRAME_CYC);
    check_int("post_abort_frame", high_acc, 768);

    // Randomized writes and occasional resets against the model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      logic rr, ww;
      rr = ($urandom_range(0, 1999) == 0);
      ww = ($urandom_range(0, 3) == 0);
      step(rr, ww, int'($urandom_range(0, 9)), 24'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
